mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified memory of the multi-cycle CPU. It shares the memory's MemRead/MemWrite/address/write-data port between the CPU datapath (requester 0) and a program loader/debug port (requester 1). It runs each access for a fixed memory latency, returns read data with a one-cycle acknowledge, and round-robins between the requesters when both are pending. It sits between the CPU memory-address mux and the memory block.

## Interface
Parameters:
- MEM_LAT, 1, cycles a strobe is held before read data is sampled; legal 1..15
- AW, 32, address width
- DW, 32, data width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_cpu_req  in  1  CPU access request; level, held until ack
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  AW  CPU address
- i_cpu_wdata  in  DW  CPU write data
- o_cpu_gnt  out  1  CPU owns the memory port
- o_cpu_ack  out  1  one-cycle completion pulse
- i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata  in  1/1/AW/DW  loader equivalents
- o_ld_gnt, o_ld_ack  out  1/1  loader equivalents
- o_rdata  out  DW  read data of the last completed read
- o_MemRead, o_MemWrite  out  1  memory strobes
- o_addr  out  AW  memory address
- o_WriteData  out  DW  memory write data
- i_MemData  in  DW  memory read data
- o_busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, ACK. A 4-bit down-counter `cnt` runs during ACCESS. The last_owner bit is 0 = CPU, 1 = loader.
- IDLE:
  - Sample requests.
  - If neither request is asserted, stay in IDLE.
  - If exactly one is asserted, that requester wins.
  - If both are asserted, the requester not equal to last_owner wins.
  - On a win, register owner, we, addr and wdata from the winner, load cnt = MEM_LAT, and go to ACCESS.
- ACCESS:
  - o_addr and o_WriteData come from the registered copies; later changes on requester inputs are ignored.
  - o_MemRead = !we_r; o_MemWrite = we_r.
  - Decrement cnt each cycle.
  - When cnt == 1: for a read, capture i_MemData into o_rdata. Then set last_owner = owner and go to ACK.
- ACK:
  - Pulse the owner's ack for exactly one cycle; strobes are low.
  - Go to IDLE.
- The owner's gnt is high throughout ACCESS and ACK. At most one gnt is high at any time.
- o_rdata holds its value until the next read capture; writes do not change it.
- A request dropped while in IDLE before it wins is simply not served.
- A request dropped during ACCESS/ACK does not abort the access; ack still pulses.
- A requester must hold req until it sees ack. If req is still high in the IDLE cycle after its ack, that is a new request.
- Outside ACCESS, o_MemRead = o_MemWrite = 0. o_addr and o_WriteData keep their registered values.

## Timing
- Reset (async, immediate):
  - state = IDLE, last_owner = 1, so the CPU wins the first tie.
  - All gnt/ack/strobes/o_busy = 0; o_rdata = 0, o_addr = 0, o_WriteData = 0.
- Reset mid-access: strobes drop asynchronously, no ack is issued, and the access is lost. The requester re-requests after reset.
- Request high in IDLE cycle T gives:
  - ACCESS during T+1..T+MEM_LAT
  - rdata valid and ack high at T+MEM_LAT+1
  - IDLE at T+MEM_LAT+2
- Request-to-ack latency is MEM_LAT+1 cycles. Throughput is one access per MEM_LAT+2 cycles.
- Memory data must be valid by the end of the MEM_LAT-th strobe cycle.
- Both requests continuously high: grants alternate CPU, loader, CPU, …; neither is starved.
- MEM_LAT = 1: ACCESS lasts exactly one cycle, with capture on that edge.

## Test plan
- Reset, then a single CPU read of 0x0000_0010 (memory word 0x1234_5678), MEM_LAT=1:
  - o_MemRead is high exactly 1 cycle with o_addr=0x10.
  - o_cpu_ack pulses the next cycle with o_rdata=0x1234_5678.
  - o_ld_gnt stays 0 throughout.
- Loader write of 0xDEAD_BEEF to 0x40, MEM_LAT=3:
  - o_MemWrite is high 3 cycles with o_WriteData=0xDEAD_BEEF.
  - o_ld_ack arrives 4 cycles after the request; o_rdata is unchanged.
- Both requests held high for 4 accesses:
  - Owners are CPU, loader, CPU, loader.
  - Gnts are never simultaneously high.
  - Each ack is 1 cycle wide.
- During CPU ACCESS, change i_cpu_addr and drop i_cpu_req:
  - o_addr keeps the original value.
  - The ack is still issued.
  - The next IDLE serves the loader only if it is requesting.
- Assert i_rst_n=0 in the 2nd ACCESS cycle (MEM_LAT=3):
  - Strobes and gnt drop the same cycle; no ack.
  - After release, the first tie goes to the CPU.
- Loader requests alone repeatedly, then the CPU joins while the loader is in ACCESS:
  - The CPU wins the next IDLE because last_owner=loader.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported unified memory of the multi-cycle CPU between the
// CPU datapath (requester 0) and the program loader / debug port
// (requester 1). Each access is sequenced as IDLE -> ACCESS (MEM_LAT cycles)
// -> ACK (one cycle). When both requesters are pending in IDLE, the one that
// was not served last wins, so neither requester can be starved.
//
// Parameters:
//   MEM_LAT  strobe cycles before read data is sampled (legal 1..15)
//   AW       address width
//   DW       data width
//
// Ports:
//   i_clk, i_rst_n                       clock (rising edge), async active-low reset
//   i_cpu_req/we/addr/wdata              CPU request (level, held until ack)
//   o_cpu_gnt, o_cpu_ack                 CPU owns the port / one-cycle completion
//   i_ld_req/we/addr/wdata               loader request (level, held until ack)
//   o_ld_gnt, o_ld_ack                   loader owns the port / one-cycle completion
//   o_rdata                              data of the last completed read
//   o_MemRead, o_MemWrite                memory strobes (only during ACCESS)
//   o_addr, o_WriteData                  registered memory address / write data
//   i_MemData                            memory read data
//   o_busy                               high whenever the sequencer is not idle
//
// All outputs are registered: each output register is loaded from the value
// the corresponding signal must have in the next state, so outputs line up
// with the state register and drop immediately on reset.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_ack,
  input  logic          i_ld_req,
  input  logic          i_ld_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_wdata,
  output logic          o_ld_gnt,
  output logic          o_ld_ack,
  output logic [DW-1:0] o_rdata,
  output logic          o_MemRead,
  output logic          o_MemWrite,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_WriteData,
  input  logic [DW-1:0] i_MemData,
  output logic          o_busy
);

  // Out-of-range latencies are clamped into the 4-bit counter range 1..15.
  localparam int       LP_LAT_CLAMP = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 15) ? 15 : MEM_LAT);
  localparam logic [3:0] LP_LAT     = LP_LAT_CLAMP[3:0];

  // Owner encoding, shared by r_owner and r_last_owner.
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  // State and sequencing registers
  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_owner;
  logic            r_last_owner;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;

  // Registered outputs
  logic            r_cpu_gnt;
  logic            r_ld_gnt;
  logic            r_cpu_ack;
  logic            r_ld_ack;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_busy;

  // Next-state values
  state_t          w_nxt_state;
  logic [3:0]      w_nxt_cnt;
  logic            w_nxt_owner;
  logic            w_nxt_last_owner;
  logic            w_nxt_we;
  logic [AW-1:0]   w_nxt_addr;
  logic [DW-1:0]   w_nxt_wdata;
  logic            w_capture;
  logic            w_win;
  logic            w_win_owner;

  // Arbitration and next-state / next-datapath logic
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cnt        = r_cnt;
    w_nxt_owner      = r_owner;
    w_nxt_last_owner = r_last_owner;
    w_nxt_we         = r_we;
    w_nxt_addr       = r_addr;
    w_nxt_wdata      = r_wdata;
    w_capture        = 1'b0;
    w_win            = 1'b0;
    w_win_owner      = OWN_CPU;

    case (r_state)
      ST_IDLE: begin
        // A tie goes to whichever requester was not served last.
        if (i_cpu_req && i_ld_req) begin
          w_win       = 1'b1;
          w_win_owner = ~r_last_owner;
        end else if (i_cpu_req) begin
          w_win       = 1'b1;
          w_win_owner = OWN_CPU;
        end else if (i_ld_req) begin
          w_win       = 1'b1;
          w_win_owner = OWN_LD;
        end else begin
          w_win       = 1'b0;
          w_win_owner = OWN_CPU;
        end

        if (w_win) begin
          w_nxt_state = ST_ACCESS;
          w_nxt_owner = w_win_owner;
          w_nxt_cnt   = LP_LAT;
          if (w_win_owner == OWN_LD) begin
            w_nxt_we    = i_ld_we;
            w_nxt_addr  = i_ld_addr;
            w_nxt_wdata = i_ld_wdata;
          end else begin
            w_nxt_we    = i_cpu_we;
            w_nxt_addr  = i_cpu_addr;
            w_nxt_wdata = i_cpu_wdata;
          end
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        w_nxt_cnt = r_cnt - 4'd1;
        // "<= 1" also recovers from a corrupted zero count instead of
        // wrapping round for 15 more cycles.
        if (r_cnt <= 4'd1) begin
          w_nxt_state      = ST_ACK;
          w_nxt_last_owner = r_owner;
          w_capture        = ~r_we;
        end else begin
          w_nxt_state = ST_ACCESS;
        end
      end

      ST_ACK: begin
        w_nxt_state = ST_IDLE;
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Access bookkeeping: counter, owner, fairness bit and latched request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= 4'd0;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_LD;
      r_we         <= 1'b0;
      r_addr       <= {AW{1'b0}};
      r_wdata      <= {DW{1'b0}};
    end else begin
      r_cnt        <= w_nxt_cnt;
      r_owner      <= w_nxt_owner;
      r_last_owner <= w_nxt_last_owner;
      r_we         <= w_nxt_we;
      r_addr       <= w_nxt_addr;
      r_wdata      <= w_nxt_wdata;
    end
  end

  // Read-data holding register, only updated on the last strobe cycle of a read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= {DW{1'b0}};
    end else if (w_capture) begin
      r_rdata <= i_MemData;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // Grant, ack, strobe and busy registers, decoded from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cpu_gnt   <= 1'b0;
      r_ld_gnt    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_ld_ack    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cpu_gnt   <= (w_nxt_state != ST_IDLE) && (w_nxt_owner == OWN_CPU);
      r_ld_gnt    <= (w_nxt_state != ST_IDLE) && (w_nxt_owner == OWN_LD);
      r_cpu_ack   <= (w_nxt_state == ST_ACK)  && (w_nxt_owner == OWN_CPU);
      r_ld_ack    <= (w_nxt_state == ST_ACK)  && (w_nxt_owner == OWN_LD);
      r_mem_read  <= (w_nxt_state == ST_ACCESS) && !w_nxt_we;
      r_mem_write <= (w_nxt_state == ST_ACCESS) &&  w_nxt_we;
      r_busy      <= (w_nxt_state != ST_IDLE);
    end
  end

  assign o_cpu_gnt   = r_cpu_gnt;
  assign o_ld_gnt    = r_ld_gnt;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_ld_ack    = r_ld_ack;
  assign o_MemRead   = r_mem_read;
  assign o_MemWrite  = r_mem_write;
  assign o_addr      = r_addr;
  assign o_WriteData = r_wdata;
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Instance u_a runs with MEM_LAT=1,
// instance u_b with MEM_LAT=3; both share clock and reset. Memory is a fixed
// combinational function of the address.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;

  // Instance A (MEM_LAT = 1)
  logic        a_cpu_req, a_cpu_we, a_ld_req, a_ld_we;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_ld_addr, a_ld_wdata;
  logic        a_cpu_gnt, a_cpu_ack, a_ld_gnt, a_ld_ack;
  logic [31:0] a_rdata, a_addr, a_wd, a_mdata;
  logic        a_mr, a_mw, a_busy;

  // Instance B (MEM_LAT = 3)
  logic        b_cpu_req, b_cpu_we, b_ld_req, b_ld_we;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_ld_addr, b_ld_wdata;
  logic        b_cpu_gnt, b_cpu_ack, b_ld_gnt, b_ld_ack;
  logic [31:0] b_rdata, b_addr, b_wd, b_mdata;
  logic        b_mr, b_mw, b_busy;

  int n_vec;
  int n_miss;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    else                    return a ^ 32'hA5A5_0000;
  endfunction

  assign a_mdata = mem_word(a_addr);
  assign b_mdata = mem_word(b_addr);

  mem_port_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(a_cpu_req), .i_cpu_we(a_cpu_we), .i_cpu_addr(a_cpu_addr), .i_cpu_wdata(a_cpu_wdata),
    .o_cpu_gnt(a_cpu_gnt), .o_cpu_ack(a_cpu_ack),
    .i_ld_req(a_ld_req), .i_ld_we(a_ld_we), .i_ld_addr(a_ld_addr), .i_ld_wdata(a_ld_wdata),
    .o_ld_gnt(a_ld_gnt), .o_ld_ack(a_ld_ack),
    .o_rdata(a_rdata), .o_MemRead(a_mr), .o_MemWrite(a_mw),
    .o_addr(a_addr), .o_WriteData(a_wd), .i_MemData(a_mdata), .o_busy(a_busy)
  );

  mem_port_arbiter #(.MEM_LAT(3), .AW(32), .DW(32)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(b_cpu_req), .i_cpu_we(b_cpu_we), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata(b_cpu_wdata),
    .o_cpu_gnt(b_cpu_gnt), .o_cpu_ack(b_cpu_ack),
    .i_ld_req(b_ld_req), .i_ld_we(b_ld_we), .i_ld_addr(b_ld_addr), .i_ld_wdata(b_ld_wdata),
    .o_ld_gnt(b_ld_gnt), .o_ld_ack(b_ld_ack),
    .o_rdata(b_rdata), .o_MemRead(b_mr), .o_MemWrite(b_mw),
    .o_addr(b_addr), .o_WriteData(b_wd), .i_MemData(b_mdata), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the control outputs of instance B in one go.
  task automatic exp_b(input string tag, input logic cg, input logic lg, input logic ca,
                       input logic la, input logic mr, input logic mw);
    chk_val({tag, ".cpu_gnt"}, {31'd0, b_cpu_gnt}, {31'd0, cg});
    chk_val({tag, ".ld_gnt"},  {31'd0, b_ld_gnt},  {31'd0, lg});
    chk_val({tag, ".cpu_ack"}, {31'd0, b_cpu_ack}, {31'd0, ca});
    chk_val({tag, ".ld_ack"},  {31'd0, b_ld_ack},  {31'd0, la});
    chk_val({tag, ".MemRead"}, {31'd0, b_mr},      {31'd0, mr});
    chk_val({tag, ".MemWrite"},{31'd0, b_mw},      {31'd0, mw});
    chk_val({tag, ".gnt_excl"},{31'd0, b_cpu_gnt & b_ld_gnt}, 32'd0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = 32'd0; a_cpu_wdata = 32'd0;
    a_ld_req  = 1'b0; a_ld_we  = 1'b0; a_ld_addr  = 32'd0; a_ld_wdata  = 32'd0;
    b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = 32'd0; b_cpu_wdata = 32'd0;
    b_ld_req  = 1'b0; b_ld_we  = 1'b0; b_ld_addr  = 32'd0; b_ld_wdata  = 32'd0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // ---------------- reset state ----------------
    exp_b("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("rst.b_busy",  {31'd0, b_busy}, 32'd0);
    chk_val("rst.b_rdata", b_rdata, 32'd0);
    chk_val("rst.b_addr",  b_addr,  32'd0);
    chk_val("rst.b_wd",    b_wd,    32'd0);
    chk_val("rst.a_busy",  {31'd0, a_busy}, 32'd0);
    chk_val("rst.a_rdata", a_rdata, 32'd0);

    // ---------------- CPU read, MEM_LAT=1 ----------------
    a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h0000_0010;
    step();
    chk_val("t1.mr_on",   {31'd0, a_mr},      32'd1);
    chk_val("t1.addr",    a_addr,             32'h0000_0010);
    chk_val("t1.gnt",     {31'd0, a_cpu_gnt}, 32'd1);
    chk_val("t1.ack_early",{31'd0, a_cpu_ack},32'd0);
    chk_val("t1.ldgnt0",  {31'd0, a_ld_gnt},  32'd0);
    step();
    chk_val("t1.mr_off",  {31'd0, a_mr},      32'd0);
    chk_val("t1.ack",     {31'd0, a_cpu_ack}, 32'd1);
    chk_val("t1.rdata",   a_rdata,            32'h1234_5678);
    chk_val("t1.ldgnt1",  {31'd0, a_ld_gnt},  32'd0);
    a_cpu_req = 1'b0;
    step();
    chk_val("t1.ack_1cyc",{31'd0, a_cpu_ack}, 32'd0);
    chk_val("t1.idle",    {31'd0, a_busy},    32'd0);
    chk_val("t1.ldgnt2",  {31'd0, a_ld_gnt},  32'd0);

    // ---------------- loader write, MEM_LAT=3 ----------------
    b_ld_req = 1'b1; b_ld_we = 1'b1; b_ld_addr = 32'h0000_0040; b_ld_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp_b("t2.acc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_val("t2.wd",   b_wd,   32'hDEAD_BEEF);
      chk_val("t2.addr", b_addr, 32'h0000_0040);
    end
    step();
    exp_b("t2.ack", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_val("t2.rdata_kept", b_rdata, 32'd0);
    b_ld_req = 1'b0; b_ld_we = 1'b0;
    step();
    exp_b("t2.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- both requesting, 4 accesses ----------------
    // CPU reads, loader writes; last owner is the loader, so CPU goes first.
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h0000_0010;
    b_ld_req  = 1'b1; b_ld_we  = 1'b1; b_ld_addr  = 32'h0000_0080; b_ld_wdata = 32'h0000_00AA;
    for (int k = 1; k <= 20; k++) begin
      int ph;
      logic own;
      ph  = (k - 1) % 5;
      own = (((k - 1) / 5) % 2) == 1;
      step();
      if (ph < 3)
        exp_b("t3.acc", ~own, own, 1'b0, 1'b0, ~own, own);
      else if (ph == 3)
        exp_b("t3.ack", ~own, own, ~own, own, 1'b0, 1'b0);
      else
        exp_b("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    b_cpu_req = 1'b0; b_ld_req = 1'b0;
    chk_val("t3.rdata", b_rdata, 32'h1234_5678);
    step();

    // ---------------- CPU changes addr / drops req mid-access ----------------
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h0000_0020;
    step();
    exp_b("t4.acc1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    b_cpu_addr = 32'h0000_0099; b_cpu_req = 1'b0;
    b_ld_req = 1'b1; b_ld_we = 1'b0; b_ld_addr = 32'h0000_0084;
    step();
    chk_val("t4.addr_hold2", b_addr, 32'h0000_0020);
    step();
    chk_val("t4.addr_hold3", b_addr, 32'h0000_0020);
    exp_b("t4.acc3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    exp_b("t4.ack", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_val("t4.rdata", b_rdata, 32'hA5A5_0020);
    step();
    exp_b("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp_b("t4.ld_acc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_val("t4.ld_addr", b_addr, 32'h0000_0084);
    step();
    step();
    step();
    exp_b("t4.ld_ack", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_val("t4.ld_rdata", b_rdata, 32'hA5A5_0084);
    b_ld_req = 1'b0;
    step();

    // ---------------- reset in 2nd ACCESS cycle ----------------
    b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 32'h0000_0030; b_cpu_wdata = 32'h0000_0055;
    step();
    exp_b("t5.acc1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    exp_b("t5.acc2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    exp_b("t5.in_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_val("t5.busy", {31'd0, b_busy}, 32'd0);
    step();
    exp_b("t5.no_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    b_ld_req = 1'b1; b_ld_we = 1'b0; b_ld_addr = 32'h0000_0088;
    rst_n = 1'b1;
    step();
    exp_b("t5.tie_cpu", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    exp_b("t5.cpu_ack", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    b_cpu_req = 1'b0;

    // ---------------- loader alone, then CPU joins ----------------
    step();
    exp_b("t6.idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp_b("t6.ld1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    step();
    exp_b("t6.ld1_ack", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    exp_b("t6.ld2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 32'h0000_0010;
    step();
    step();
    step();
    exp_b("t6.ld2_ack", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    exp_b("t6.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    exp_b("t6.cpu_wins", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    b_cpu_req = 1'b0; b_ld_req = 1'b0;
    step();
    step();
    step();
    exp_b("t6.cpu_ack", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_val("t6.rdata", b_rdata, 32'h1234_5678);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
